decrementer_serial_unit: RTL and testbench



---
 rtl/decrementer_serial_unit.sv | 112 +++++++++++
 tb/tb_decrementer_serial_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/decrementer_serial_unit.sv
// Bit-serial 4-bit decrementer: captures A or B on Start and ripples a borrow LSB first.
// Optional DEC_SATURATE_EN macro: an operand of zero yields Out=0 instead of wrapping to F.
module decrementer_serial_unit (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  input  logic       Sel,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       Ready,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] Out,
  output logic       Borrow_Out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_reg;
  logic [3:0] op_reg;
  logic [3:0] res_reg;
  logic [3:0] out_reg;
  logic [1:0] bit_cnt_reg;
  logic       borrow_reg;
  logic       borrow_out_reg;
  logic       ready_reg;
  logic       busy_reg;
  logic       done_reg;

  logic [3:0] res_next;
  logic       borrow_next;
  logic [3:0] final_out;

  assign borrow_next = ~op_reg[bit_cnt_reg] & borrow_reg;

  // Only the bit selected by the counter changes; the rest of the partial result is kept.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_res_bit
      assign res_next[gi] = (bit_cnt_reg == 2'(gi)) ? (op_reg[gi] ^ borrow_reg) : res_reg[gi];
    end
  endgenerate

  // A borrow surviving the last bit means the operand was zero.
`ifdef DEC_SATURATE_EN
  assign final_out = borrow_next ? 4'h0 : res_next;
`else
  assign final_out = res_next;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg      <= IDLE;
      op_reg         <= 4'h0;
      res_reg        <= 4'h0;
      out_reg        <= 4'h0;
      bit_cnt_reg    <= 2'd0;
      borrow_reg     <= 1'b0;
      borrow_out_reg <= 1'b0;
      ready_reg      <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            op_reg      <= Sel ? B : A;
            borrow_reg  <= 1'b1;
            bit_cnt_reg <= 2'd0;
            state_reg   <= SHIFT;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b1;
          end
        end
        SHIFT: begin
          res_reg     <= res_next;
          borrow_reg  <= borrow_next;
          bit_cnt_reg <= bit_cnt_reg + 2'd1;
          if (bit_cnt_reg == 2'd3) begin
            // Output registers load on the same edge that finishes bit 3.
            out_reg        <= final_out;
            borrow_out_reg <= borrow_next;
            state_reg      <= DONE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Ready      = ready_reg;
  assign Busy       = busy_reg;
  assign Done       = done_reg;
  assign Out        = out_reg;
  assign Borrow_Out = borrow_out_reg;

endmodule

// File: tb/tb_decrementer_serial_unit.sv
// Scoreboard bench for decrementer_serial_unit; expectations pushed at accept, checked on Done.
// Honours DEC_SATURATE_EN the same way as the design.
module tb_decrementer_serial_unit;

  logic       Clk;
  logic       Rst_n;
  logic       Start;
  logic       Sel;
  logic [3:0] A;
  logic [3:0] B;
  logic       Ready;
  logic       Busy;
  logic       Done;
  logic [3:0] Out;
  logic       Borrow_Out;

  decrementer_serial_unit dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Start      (Start),
    .Sel        (Sel),
    .A          (A),
    .B          (B),
    .Ready      (Ready),
    .Busy       (Busy),
    .Done       (Done),
    .Out        (Out),
    .Borrow_Out (Borrow_Out)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_count = 0;
  int last_done_cyc = 0;
  bit have_last = 1'b0;
  bit b2b_mode  = 1'b0;
  logic [4:0] exp_q[$];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {borrow, result}
  function automatic logic [4:0] model(input logic [3:0] op);
    logic [3:0] r;
    if (op == 4'h0) begin
`ifdef DEC_SATURATE_EN
      r = 4'h0;
`else
      r = 4'hF;
`endif
      return {1'b1, r};
    end
    r = op - 4'h1;
    return {1'b0, r};
  endfunction

  // Scoreboard consumer.
  always @(negedge Clk) begin
    if (Rst_n && Done) begin
      logic [4:0] e;
      done_count++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 32'(Done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out", 32'(Out), 32'(e[3:0]));
        check_eq("borrow_out", 32'(Borrow_Out), 32'(e[4]));
      end
      if (b2b_mode && have_last) check_eq("done_gap", 32'(cyc - last_done_cyc), 32'd6);
      last_done_cyc = cyc;
      have_last = 1'b1;
    end
  end

  // Called just after a rising edge while IDLE; returns just after the accept edge.
  task automatic start_op(input logic s, input logic [3:0] a, input logic [3:0] b, input bit push);
    Sel = s; A = a; B = b; Start = 1'b1;
    if (push) exp_q.push_back(model(s ? b : a));
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    @(negedge Clk);
    while (!Done && n < 12) begin
      @(negedge Clk);
      n++;
    end
    check_eq("done_seen", 32'(Done), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    Rst_n = 1'b0; Start = 1'b0; Sel = 1'b0; A = 4'h0; B = 4'h0;

    // Reset
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(negedge Clk);
    check_eq("rst_ready", 32'(Ready), 32'd1);
    check_eq("rst_busy", 32'(Busy), 32'd0);
    check_eq("rst_done", 32'(Done), 32'd0);
    check_eq("rst_out", 32'(Out), 32'd0);
    check_eq("rst_borrow", 32'(Borrow_Out), 32'd0);
    @(posedge Clk); #1;

    // A path, B scrambled during SHIFT
    start_op(1'b0, 4'h8, 4'h2, 1'b1);
    B = 4'hF; Sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check_eq("busy_shift", 32'(Busy), 32'd1);
      check_eq("ready_shift", 32'(Ready), 32'd0);
      check_eq("done_shift", 32'(Done), 32'd0);
      if (i == 1) check_eq("out_hold_shift", 32'(Out), 32'd0);
    end
    @(negedge Clk);
    check_eq("done_pulse", 32'(Done), 32'd1);
    check_eq("busy_in_done", 32'(Busy), 32'd0);
    @(negedge Clk);
    check_eq("done_one_cycle", 32'(Done), 32'd0);
    check_eq("ready_after", 32'(Ready), 32'd1);
    check_eq("out_hold_idle", 32'(Out), 32'd7);
    @(posedge Clk); #1;

    // B path, zero operand
    start_op(1'b1, 4'h6, 4'h0, 1'b1);
    wait_done();
    @(posedge Clk); #1;

    // Start during SHIFT is ignored
    dc = done_count;
    start_op(1'b0, 4'h5, 4'h1, 1'b1);
    Start = 1'b1; A = 4'h9;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done();
    repeat (12) @(negedge Clk);
    check_eq("single_done", 32'(done_count - dc), 32'd1);
    check_eq("held_out_4", 32'(Out), 32'd4);
    @(posedge Clk); #1;

    // Reset mid-SHIFT aborts
    dc = done_count;
    start_op(1'b0, 4'h3, 4'h0, 1'b0);
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    check_eq("abort_ready", 32'(Ready), 32'd1);
    check_eq("abort_busy", 32'(Busy), 32'd0);
    check_eq("abort_out", 32'(Out), 32'd0);
    repeat (8) @(negedge Clk);
    check_eq("abort_no_done", 32'(done_count - dc), 32'd0);

    // Reset wins over a simultaneous Start
    @(posedge Clk); #1;
    Rst_n = 1'b0; Start = 1'b1; A = 4'hA; Sel = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1; Start = 1'b0;
    @(negedge Clk);
    check_eq("rst_start_ready", 32'(Ready), 32'd1);
    check_eq("rst_start_busy", 32'(Busy), 32'd0);
    @(posedge Clk); #1;

    // Back-to-back sweep with Start held high
    dc = done_count;
    b2b_mode = 1'b1; have_last = 1'b0;
    Start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      logic [4:0] iv;
      logic [3:0] other;
      iv = 5'(i);
      other = 4'($urandom_range(0, 15));
      Sel = iv[4];
      A = iv[4] ? other : iv[3:0];
      B = iv[4] ? iv[3:0] : other;
      exp_q.push_back(model(iv[3:0]));
      @(posedge Clk); #1;
      A = 4'($urandom_range(0, 15)); B = 4'($urandom_range(0, 15)); Sel = ~Sel;
      if (i == 31) Start = 1'b0;
      else begin
        repeat (5) @(posedge Clk);
        #1;
      end
    end
    wait_done();
    repeat (3) @(negedge Clk);
    b2b_mode = 1'b0;
    check_eq("sweep_count", 32'(done_count - dc), 32'd32);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
